mod5_serial_scheduler: RTL and testbench

- Shares one bit-serial, MSB-first mod-5 residue datapath between two requesters.
- Each requester presents a parallel W-bit word through a valid/ready handshake. A round-robin arbiter picks one requester, the block shifts the word MSB-first through the residue engine, and the block returns the 3-bit residue plus the requester id through an output valid/ready handshake.
- Sits between parallel-word producers and any consumer of mod-5 results in the sequential-circuits lab design.

---
 rtl/mod5_serial_scheduler.sv | 154 +++++++++++++++
 tb/tb_mod5_serial_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mod5_serial_scheduler.sv
// Two-requester round-robin front end for a bit-serial MSB-first mod-5 residue engine.
// Optional per-requester job counters and starvation flag under MOD5_SCHED_STATS_EN.
module mod5_serial_scheduler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         res_valid,
  output logic [2:0]   res_value,
  output logic         res_id,
  output logic         res_divisible,
  input  logic         res_ready,
  output logic         busy
`ifdef MOD5_SCHED_STATS_EN
  ,
  output logic [7:0]   jobs0,
  output logic [7:0]   jobs1,
  output logic         starve_flag
`endif
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         r_state, w_next;
  logic           r_rr_ptr;
  logic           r_owner;
  logic [2:0]     r_residue;
  logic [W-1:0]   r_sreg;
  logic [IW-1:0]  r_idx;

  logic           w_grant;
  logic           w_hs0, w_hs1, w_hs;
  logic           w_res_hs;

  // {r, b} is 2r+b (at most 9), so a single conditional subtract keeps it in 0..4
  function automatic logic [2:0] f_step(input logic [2:0] r, input logic b);
    logic [3:0] t;
    t = {r, b};
    if (t >= 4'd5) t = t - 4'd5;
    return t[2:0];
  endfunction

  assign w_grant  = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;
  assign w_hs0    = req0_valid & req0_ready;
  assign w_hs1    = req1_valid & req1_ready;
  assign w_hs     = w_hs0 | w_hs1;
  assign w_res_hs = res_valid & res_ready;

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = SHIFT;
      SHIFT:   if (r_idx == '0) w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    res_value  = 3'd0;
    res_id     = 1'b0;
    busy       = (r_state != IDLE);
    if (r_state == IDLE && !reset) begin
      req0_ready = req0_valid & ~w_grant;
      req1_ready = req1_valid &  w_grant;
    end
    if (r_state == DONE) begin
      res_valid = 1'b1;
      res_value = r_residue;
      res_id    = r_owner;
    end
  end

  assign res_divisible = res_valid & (res_value == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr  <= 1'b0;
      r_owner   <= 1'b0;
      r_residue <= 3'd0;
      r_sreg    <= '0;
      r_idx     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_sreg    <= w_hs1 ? req1_data : req0_data;
          r_owner   <= w_hs1;
          r_residue <= 3'd0;
          r_idx     <= IW'(W-1);
        end
        SHIFT: begin
          r_residue <= f_step(r_residue, r_sreg[W-1]);
          r_sreg    <= {r_sreg[W-2:0], 1'b0};
          r_idx     <= r_idx - 1'b1;
        end
        DONE: if (res_ready) r_rr_ptr <= ~r_owner;
        default: ;
      endcase
    end
  end

`ifdef MOD5_SCHED_STATS_EN
  localparam int STARVE_LIM = 2 * (W + 2);

  logic [7:0] r_jobs0, r_jobs1, r_wait0, r_wait1;
  logic       r_starve;
  logic       w_wait0, w_wait1;

  assign w_wait0 = req0_valid & ~w_hs0;
  assign w_wait1 = req1_valid & ~w_hs1;

  // wait counters saturate; the flag trips on the cycle that exceeds the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jobs0  <= 8'd0;
      r_jobs1  <= 8'd0;
      r_wait0  <= 8'd0;
      r_wait1  <= 8'd0;
      r_starve <= 1'b0;
    end else begin
      if (w_res_hs && !r_owner) r_jobs0 <= r_jobs0 + 8'd1;
      if (w_res_hs &&  r_owner) r_jobs1 <= r_jobs1 + 8'd1;
      r_wait0 <= !w_wait0 ? 8'd0 : (r_wait0 == 8'hFF) ? r_wait0 : r_wait0 + 8'd1;
      r_wait1 <= !w_wait1 ? 8'd0 : (r_wait1 == 8'hFF) ? r_wait1 : r_wait1 + 8'd1;
      if ((w_wait0 && r_wait0 >= 8'(STARVE_LIM)) || (w_wait1 && r_wait1 >= 8'(STARVE_LIM)))
        r_starve <= 1'b1;
    end
  end

  assign jobs0       = r_jobs0;
  assign jobs1       = r_jobs1;
  assign starve_flag = r_starve;
`endif

endmodule

// File: tb/tb_mod5_serial_scheduler.sv
// Directed bench for mod5_serial_scheduler: expected residues queued on accept, checked on result handshake.
module tb_mod5_serial_scheduler;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_id, res_divisible, res_ready, busy;
  logic [2:0]   res_value;
`ifdef MOD5_SCHED_STATS_EN
  logic [7:0]   jobs0, jobs1;
  logic         starve_flag;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  mod5_serial_scheduler #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_value(res_value), .res_id(res_id),
    .res_divisible(res_divisible), .res_ready(res_ready), .busy(busy)
`ifdef MOD5_SCHED_STATS_EN
    , .jobs0(jobs0), .jobs1(jobs1), .starve_flag(starve_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: a result handshake completes on the posedge after this negedge
  always @(negedge clk) begin
    if (reset === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_result: observed id=%0d value=%0d, expected no result", res_id, res_value);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("res_value", res_value, e[2:0]);
        chk("res_id", res_id, e[3]);
        chk("res_divisible", res_divisible, e[2:0] == 3'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // present a word, wait for its ready, optionally queue its expected result
  task automatic send(input logic id, input logic [W-1:0] d, input logic push);
    int n = 0;
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed no ready for id %0d, expected ready", id);
    end else if (push) begin
      exp_q.push_back({id, 3'(d % 5)});
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: observed %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic lat_bad;
    logic [W-1:0] d;
    int n;
    reset = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h36;
    req1_valid = 1'b0; req1_data = '0;

    // reset state, with a requester already valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_value", res_value, 3'd0);
    chk("rst_res_id", res_id, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // single job latency: 54 mod 5 = 4
    send(1'b0, 8'h36, 1'b1);
    lat_bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) lat_bad = 1'b1;
    end
    chk("latency_early", lat_bad, 1'b0);
    @(negedge clk);
    chk("latency_valid", res_valid, 1'b1);
    @(negedge clk);
    chk("busy_after_result", busy, 1'b0);

    // tie alternation from a fresh pointer: grants 0,1,0
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hFF;
    req1_valid = 1'b1; req1_data = 8'h1F;
    for (int j = 0; j < 3; j++) begin
      logic eid;
      eid = (j == 1);
      n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 100) begin @(negedge clk); n++; end
      chk("grant_order", req1_ready, eid);
      d = eid ? 8'h1F : 8'hFF;
      exp_q.push_back({eid, 3'(d % 5)});
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // result held under backpressure; no ready while DONE
    res_ready = 1'b0;
    send(1'b1, 8'hD3, 1'b1);
    req0_valid = 1'b1; req0_data = 8'h0A;
    n = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_value", res_value, 3'd1);
      chk("hold_id", res_id, 1'b1);
      chk("hold_no_ready", req0_ready | req1_ready, 1'b0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    send(1'b0, 8'h0A, 1'b1);
    drain();

    // reset in the 4th SHIFT cycle drops the job
    send(1'b0, 8'hC7, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_res_valid", res_valid, 1'b0);
    repeat (12) @(negedge clk);
    chk("abort_no_result", res_valid, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'hC7;
    req1_valid = 1'b1; req1_data = 8'h12;
    @(negedge clk);
    chk("tie_after_reset_r0", req0_ready, 1'b1);
    chk("tie_after_reset_r1", req1_ready, 1'b0);
    exp_q.push_back({1'b0, 3'(8'hC7 % 5)});
    @(posedge clk); #1 req0_valid = 1'b0;
    send(1'b1, 8'h12, 1'b1);
    drain();

    // every word through requester 0
    do_reset();
    for (int w = 0; w < 255; w++) send(1'b0, 8'(w), 1'b1);
    drain();
`ifdef MOD5_SCHED_STATS_EN
    chk("jobs0_255", jobs0, 8'd255);
`endif
    send(1'b0, 8'hFF, 1'b1);
    drain();
`ifdef MOD5_SCHED_STATS_EN
    chk("jobs0_wrap", jobs0, 8'd0);
    chk("jobs1_zero", jobs1, 8'd0);
    chk("starve_clear", starve_flag, 1'b0);
`endif
    chk("final_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
